shared_mem_arbiter: RTL and testbench



---
 rtl/shared_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter giving two MIPS cores exclusive, timed access to one
// shared memory port; each grant holds the port for ACCESS_CYCLES cycles.
module shared_mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] wd1,
  output logic [DW-1:0] rd1,
  output logic          ack1,
  output logic          stall1,
  input  logic          req2,
  input  logic          we2,
  input  logic [AW-1:0] a2,
  input  logic [DW-1:0] wd2,
  output logic [DW-1:0] rd2,
  output logic          ack2,
  output logic          stall2,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    o_dbg_state
);

  // Handshake: reqN is a level held with weN/aN/wdN stable until ackN; ackN is
  // a one-cycle pulse in the IDLE cycle after the grant; stallN = reqN && !ackN.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY1 = 2'd1,
    BUSY2 = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;
  logic          r_last2;
  logic          r_we;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic          r_ack1;
  logic          r_ack2;
  logic          w_elig1;
  logic          w_elig2;
  logic          w_busy;
  logic          w_done;
  logic          w_grant1;
  logic          w_grant2;

  // A core being acked this cycle is not eligible, so it cannot be re-granted.
  assign w_elig1 = req1 && !r_ack1;
  assign w_elig2 = req2 && !r_ack2;
  assign w_busy  = (r_state != IDLE);
  assign w_done  = w_busy && (r_cnt == 4'd0);

  always_comb begin
    w_next_state = r_state;
    w_grant1     = 1'b0;
    w_grant2     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig1 && w_elig2) begin
          w_grant1 = r_last2;
          w_grant2 = !r_last2;
        end else begin
          w_grant1 = w_elig1;
          w_grant2 = w_elig2;
        end
        if (w_grant1)      w_next_state = BUSY1;
        else if (w_grant2) w_next_state = BUSY2;
      end
      BUSY1, BUSY2: begin
        if (r_cnt == 4'd0) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_last2 <= 1'b1;
      r_we    <= 1'b0;
      r_a     <= '0;
      r_wd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_ack1  <= 1'b0;
      r_ack2  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack1  <= 1'b0;
      r_ack2  <= 1'b0;
      // The captured copy drives the port for the whole grant.
      if (w_grant1) begin
        r_we  <= we1;
        r_a   <= a1;
        r_wd  <= wd1;
        r_cnt <= CNT_LOAD;
      end else if (w_grant2) begin
        r_we  <= we2;
        r_a   <= a2;
        r_wd  <= wd2;
        r_cnt <= CNT_LOAD;
      end else if (w_busy && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        if (r_state == BUSY1) begin
          r_ack1  <= 1'b1;
          r_last2 <= 1'b0;
          if (!r_we) r_rd1 <= mem_rd;
        end else begin
          r_ack2  <= 1'b1;
          r_last2 <= 1'b1;
          if (!r_we) r_rd2 <= mem_rd;
        end
      end
    end
  end

  assign mem_we      = w_busy && r_we;
  assign mem_a       = w_busy ? r_a  : '0;
  assign mem_wd      = w_busy ? r_wd : '0;
  assign rd1         = r_rd1;
  assign rd2         = r_rd2;
  assign ack1        = r_ack1;
  assign ack2        = r_ack2;
  assign stall1      = w_elig1;
  assign stall2      = w_elig2;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed steps followed by randomized traffic,
// checked against a transaction-level model of the shared memory.
module tb_shared_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AC = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY1 = 2'd1;
  localparam logic [1:0] ST_BUSY2 = 2'd2;

  logic          clk;
  logic          reset;
  logic          req1, we1, ack1, stall1;
  logic          req2, we2, ack2, stall2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] wd1, wd2, rd1, rd2;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic [1:0]    dbg_state;

  // Physical memory behind the port, plus preload path.
  logic [DW-1:0] tb_mem [256];
  logic          pl_en;
  logic [7:0]    pl_a;
  logic [DW-1:0] pl_d;

  // Scoreboard state.
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] exp_rd1, exp_rd2;
  logic [31:0]   exp_q[$];
  int            ack_log[$];
  logic          pend1, pend2, drop1, drop2;
  logic          t_we1, t_we2;
  logic [AW-1:0] t_a1, t_a2;
  logic [DW-1:0] t_wd1, t_wd2;
  int            raise1, raise2;
  int            cyc;
  int            n_tests, n_fail;

  shared_mem_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req1(req1), .we1(we1), .a1(a1), .wd1(wd1), .rd1(rd1), .ack1(ack1), .stall1(stall1),
    .req2(req2), .we2(we2), .a2(a2), .wd2(wd2), .rd2(rd2), .ack2(ack2), .stall2(stall2),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_a] <= pl_d;
    else if (mem_we) tb_mem[mem_a[7:0]] <= mem_wd;
  end
  assign mem_rd = tb_mem[mem_a[7:0]];

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int core, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (core == 1) begin
      req1 = 1'b1; we1 = we; a1 = a; wd1 = wd;
      t_we1 = we; t_a1 = a; t_wd1 = wd; pend1 = 1'b1; raise1 = cyc;
    end else begin
      req2 = 1'b1; we2 = we; a2 = a; wd2 = wd;
      t_we2 = we; t_a2 = a; t_wd2 = wd; pend2 = 1'b1; raise2 = cyc;
    end
  endtask

  // Completed transactions are applied to the model in ack order, which is
  // the order in which the memory port served them.
  task automatic on_ack(input int core);
    if (core == 1) begin
      if (t_we1) model_mem[t_a1[7:0]] = t_wd1;
      else       exp_rd1 = model_mem[t_a1[7:0]];
      check("rd1_after_ack", rd1, exp_rd1);
    end else begin
      if (t_we2) model_mem[t_a2[7:0]] = t_wd2;
      else       exp_rd2 = model_mem[t_a2[7:0]];
      check("rd2_after_ack", rd2, exp_rd2);
    end
  endtask

  task automatic handle_ack(input int core);
    logic outstanding;
    int   lat;
    outstanding = (core == 1) ? pend1 : pend2;
    lat         = cyc - ((core == 1) ? raise1 : raise2);
    check($sformatf("ack%0d_outstanding", core), 32'(outstanding), 32'd1);
    check($sformatf("ack%0d_latency_max", core), 32'(lat <= 2 * AC + 2), 32'd1);
    check($sformatf("ack%0d_latency_min", core), 32'(lat >= AC + 1), 32'd1);
    on_ack(core);
    ack_log.push_back(core);
    if (core == 1) begin pend1 = 1'b0; drop1 = 1'b1; end
    else begin pend2 = 1'b0; drop2 = 1'b1; end
  endtask

  // Per-cycle housekeeping: drop requests the cycle after their ack, then observe.
  task automatic service();
    if (drop1) begin req1 = 1'b0; drop1 = 1'b0; end
    if (drop2) begin req2 = 1'b0; drop2 = 1'b0; end
    #1;
    if (ack1 && ack2) check("dual_ack", 32'd1, 32'd0);
    if (ack1 === 1'b1) handle_ack(1);
    if (ack2 === 1'b1) handle_ack(2);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!pend1 && !pend2 && !drop1 && !drop2) break;
      next_cycle();
      service();
    end
    check("drain_done", 32'({pend1, pend2, drop1, drop2}), 32'd0);
    pend1 = 1'b0; pend2 = 1'b0; req1 = 1'b0; req2 = 1'b0; drop1 = 1'b0; drop2 = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] mask;
    int d1, d2;
    logic go1, go2, rr1, rr2;

    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    req1 = 0; we1 = 0; a1 = '0; wd1 = '0;
    req2 = 0; we2 = 0; a2 = '0; wd2 = '0;
    pend1 = 0; pend2 = 0; drop1 = 0; drop2 = 0;
    t_we1 = 0; t_we2 = 0; t_a1 = '0; t_a2 = '0; t_wd1 = '0; t_wd2 = '0;
    raise1 = 0; raise2 = 0; exp_rd1 = '0; exp_rd2 = '0;

    // Preload memory while reset is held.
    for (int i = 0; i < 256; i++) begin
      pl_en = 1'b1;
      pl_a  = 8'(i);
      pl_d  = (i == 8'h40) ? 32'hDEADBEEF : $urandom;
      model_mem[i] = pl_d;
      next_cycle();
    end
    pl_en = 1'b0;
    #1;
    check("rst_rd1", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);
    check("rst_acks", 32'({ack1, ack2}), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    // Uncontended read of 0x40; core 1 changes a1 mid-grant.
    next_cycle(); issue(1, 1'b0, 32'h40, 32'h0); service();
    check("t1_c0_stall1", 32'(stall1), 32'd1);
    check("t1_c0_mem_a", mem_a, 32'd0);
    next_cycle(); service();
    check("t1_c1_state", 32'(dbg_state), 32'(ST_BUSY1));
    check("t1_c1_mem_a", mem_a, 32'h40);
    check("t1_c1_stall1", 32'(stall1), 32'd1);
    check("t1_c1_ack1", 32'(ack1), 32'd0);
    next_cycle(); a1 = 32'hFF; service();
    check("t1_c2_mem_a_captured", mem_a, 32'h40);
    check("t1_c2_stall1", 32'(stall1), 32'd1);
    check("t1_c2_mem_we", 32'(mem_we), 32'd0);
    next_cycle(); service();
    check("t1_c3_ack1", 32'(ack1), 32'd1);
    check("t1_c3_rd1", rd1, 32'hDEADBEEF);
    check("t1_c3_stall1", 32'(stall1), 32'd0);
    check("t1_c3_mem_a", mem_a, 32'd0);
    check("t1_c3_state", 32'(dbg_state), 32'(ST_IDLE));
    next_cycle(); service();
    check("t1_c4_ack1", 32'(ack1), 32'd0);
    check("t1_c4_rd1_hold", rd1, 32'hDEADBEEF);

    // Reset clears rd; then simultaneous requests.
    next_cycle(); reset = 1'b1; service();
    next_cycle(); reset = 1'b0; exp_rd1 = '0; exp_rd2 = '0; service();
    check("t2_reset_rd1", rd1, 32'd0);
    next_cycle(); issue(1, 1'b0, 32'h04, 32'h0); issue(2, 1'b0, 32'h08, 32'h0); service();
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); service();
      check($sformatf("t2_c%0d_state", c), 32'(dbg_state),
            32'((c == 1 || c == 2) ? ST_BUSY1 : (c == 4 || c == 5) ? ST_BUSY2 : ST_IDLE));
      check($sformatf("t2_c%0d_ack1", c), 32'(ack1), 32'(c == 3));
      check($sformatf("t2_c%0d_ack2", c), 32'(ack2), 32'(c == 6));
    end
    next_cycle(); issue(1, 1'b0, 32'h0C, 32'h0); issue(2, 1'b0, 32'h10, 32'h0); service();
    next_cycle(); service();
    check("t2_next_tie_core1", 32'(dbg_state), 32'(ST_BUSY1));
    drain(20);

    // Core 2 write.
    next_cycle(); issue(2, 1'b1, 32'h80, 32'h12345678); service();
    check("t3_c0_mem_we", 32'(mem_we), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); service();
      check($sformatf("t3_c%0d_mem_we", c), 32'(mem_we), 32'(c != 3));
      check($sformatf("t3_c%0d_mem_a", c), mem_a, (c != 3) ? 32'h80 : 32'h0);
      check($sformatf("t3_c%0d_mem_wd", c), mem_wd, (c != 3) ? 32'h12345678 : 32'h0);
      check($sformatf("t3_c%0d_ack2", c), 32'(ack2), 32'(c == 3));
    end
    check("t3_rd2_unchanged", rd2, exp_rd2);
    next_cycle(); service();
    next_cycle(); issue(1, 1'b0, 32'h80, 32'h0); drain(20);
    check("t3_readback", rd1, 32'h12345678);

    // Reset in the second BUSY2 cycle aborts the transaction.
    next_cycle(); issue(2, 1'b0, 32'h10, 32'h0); service();
    next_cycle(); service();
    check("t5_c1_state", 32'(dbg_state), 32'(ST_BUSY2));
    next_cycle(); reset = 1'b1; service();
    check("t5_c2_state", 32'(dbg_state), 32'(ST_BUSY2));
    next_cycle(); reset = 1'b0; exp_rd1 = '0; exp_rd2 = '0; service();
    check("t5_c3_ack2", 32'(ack2), 32'd0);
    check("t5_c3_rd", 32'(rd1 | rd2), 32'd0);
    check("t5_c3_mem", 32'(mem_we) | mem_a | mem_wd, 32'd0);
    check("t5_c3_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_c3_stall2", 32'(stall2), 32'd1);
    next_cycle(); service();
    check("t5_c4_regrant", 32'(dbg_state), 32'(ST_BUSY2));
    check("t5_c4_mem_a", mem_a, 32'h10);
    drain(20);

    // Continuous contention: grants must alternate starting with core 1.
    ack_log.delete();
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back((i % 2 == 0) ? 32'd1 : 32'd2);
    rr1 = 1'b0; rr2 = 1'b0;
    next_cycle();
    issue(1, 1'(($urandom_range(0, 1))), 32'($urandom_range(0, 15) * 4), $urandom);
    issue(2, 1'(($urandom_range(0, 1))), 32'($urandom_range(0, 15) * 4), $urandom);
    service();
    for (int k = 0; k < 30; k++) begin
      next_cycle();
      if (rr1) begin issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom); rr1 = 1'b0; end
      if (rr2) begin issue(2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom); rr2 = 1'b0; end
      if (drop1) rr1 = 1'b1;
      if (drop2) rr2 = 1'b1;
      service();
    end
    check("t6_ack_count_ge8", 32'(ack_log.size() >= 8), 32'd1);
    for (int i = 0; i < ack_log.size(); i++) begin
      if (exp_q.size() == 0) begin
        check("t6_exp_q_underflow", 32'd1, 32'd0);
        break;
      end
      check($sformatf("t6_grant_%0d", i), 32'(ack_log[i]), exp_q.pop_front());
    end
    drain(20);

    // Randomized traffic with staggered starts.
    for (int it = 0; it < 25; it++) begin
      mask = 2'($urandom_range(1, 3));
      d1   = $urandom_range(0, 3);
      d2   = $urandom_range(0, 3);
      go1  = !mask[0];
      go2  = !mask[1];
      next_cycle();
      for (int k = 0; k < 40; k++) begin
        if (!go1 && k >= d1) begin
          issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom); go1 = 1'b1;
        end
        if (!go2 && k >= d2) begin
          issue(2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom); go2 = 1'b1;
        end
        service();
        if (go1 && go2 && !pend1 && !pend2 && !drop1 && !drop2) break;
        next_cycle();
      end
      check($sformatf("rand_%0d_done", it), 32'({pend1, pend2, drop1, drop2}), 32'd0);
      pend1 = 0; pend2 = 0; drop1 = 0; drop2 = 0; req1 = 0; req2 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
